mem_io_ctrl: RTL

- Memory/I-O access sequencer sitting directly below the LC-3 datapath.
- Consumes the datapath's MAR and MDR plus read/write requests from the control FSM.
- Produces the MDR_In word that feeds the datapath's MDR input mux.
- Sequences an asynchronous SRAM with a configurable number of wait states, and maps one address to switches (read) and a hex-display register (write).

---
 rtl/mem_io_ctrl_if.sv | 32 +++
 rtl/mem_io_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_io_ctrl_if.sv
// Request, data and SRAM pin bundle between the LC-3 datapath, the board and mem_io_ctrl.
// master: datapath/board side; slave: the sequencer.
interface mem_io_ctrl_if;
    logic        Mem_Rd;
    logic        Mem_Wr;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Switches;
    logic [15:0] SRAM_Data_In;
    logic [15:0] MDR_In;
    logic        Mem_Ready;
    logic        Busy;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_Data_Out;
    logic        SRAM_Data_OE;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] HEX_Data;

    modport master (
        output Mem_Rd, Mem_Wr, MAR, MDR, Switches, SRAM_Data_In,
        input  MDR_In, Mem_Ready, Busy, SRAM_ADDR, SRAM_Data_Out,
        input  SRAM_Data_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX_Data
    );

    modport slave (
        input  Mem_Rd, Mem_Wr, MAR, MDR, Switches, SRAM_Data_In,
        output MDR_In, Mem_Ready, Busy, SRAM_ADDR, SRAM_Data_Out,
        output SRAM_Data_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX_Data
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// LC-3 memory/I-O sequencer: async SRAM with WAIT_STATES strobe cycles, IO_ADDR -> switches/hex.
// Ports: Clk, Reset (async, active-low), bus (mem_io_ctrl_if.slave). All outputs registered.
module mem_io_ctrl #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    mem_io_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_WAIT  = 3'd1;
    localparam logic [2:0] WR_PULSE = 3'd2;
    localparam logic [2:0] WR_HOLD  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    logic [2:0] state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       armed, armed_d;
    logic       req, is_io, accept;

    assign req    = bus.Mem_Rd | bus.Mem_Wr;
    assign is_io  = (bus.MAR == IO_ADDR);
    assign accept = (state == IDLE) && armed && req;

    // armed blocks a request level still held after Mem_Ready
    // from starting a second access until it is dropped.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        armed_d = armed;
        unique case (1'b1)
            (state == IDLE): begin
                if (!req) begin
                    armed_d = 1'b1;
                end else if (armed) begin
                    cnt_d = CNT_INIT;
                    if (is_io)           state_d = DONE;
                    else if (bus.Mem_Rd) state_d = RD_WAIT;
                    else                 state_d = WR_PULSE;
                end
            end
            (state == RD_WAIT): begin
                if (cnt == 4'd0) state_d = DONE;
                else             cnt_d   = cnt - 4'd1;
            end
            (state == WR_PULSE): begin
                if (cnt == 4'd0) state_d = WR_HOLD;
                else             cnt_d   = cnt - 4'd1;
            end
            (state == WR_HOLD): state_d = DONE;
            (state == DONE): begin
                armed_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they
    // line up with the state they belong to and cannot glitch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            armed             <= 1'b1;
            bus.MDR_In        <= 16'h0000;
            bus.HEX_Data      <= 16'h0000;
            bus.Mem_Ready     <= 1'b0;
            bus.Busy          <= 1'b0;
            bus.SRAM_ADDR     <= 20'h00000;
            bus.SRAM_Data_Out <= 16'h0000;
            bus.SRAM_Data_OE  <= 1'b0;
            bus.SRAM_CE_N     <= 1'b1;
            bus.SRAM_OE_N     <= 1'b1;
            bus.SRAM_WE_N     <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            armed <= armed_d;

            bus.Mem_Ready    <= (state_d == DONE);
            bus.Busy         <= (state_d != IDLE);
            bus.SRAM_CE_N    <= !((state_d == RD_WAIT) ||
                                  (state_d == WR_PULSE) ||
                                  (state_d == WR_HOLD));
            bus.SRAM_OE_N    <= (state_d != RD_WAIT);
            bus.SRAM_WE_N    <= (state_d != WR_PULSE);
            bus.SRAM_Data_OE <= (state_d == WR_PULSE) ||
                                (state_d == WR_HOLD);

            if (accept) begin
                bus.SRAM_ADDR     <= {4'b0000, bus.MAR};
                bus.SRAM_Data_Out <= bus.MDR;
                // read wins over a simultaneous write
                if (is_io && bus.Mem_Rd)
                    bus.MDR_In <= bus.Switches;
                if (is_io && !bus.Mem_Rd)
                    bus.HEX_Data <= bus.MDR;
            end

            if ((state == RD_WAIT) && (cnt == 4'd0))
                bus.MDR_In <= bus.SRAM_Data_In;
        end
    end

endmodule
